// File: rtl/mem_access_unit_if.sv
// Request/response handshake and DataMemory port bundle for mem_access_unit.
// The slave modport is the unit's view; master is the requester/memory side.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_di;
  logic [31:0] mem_do;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, rsp_ready, mem_do,
    output req_ready, rsp_valid, rsp_data, rsp_err, mem_we, mem_addr, mem_di
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, rsp_ready, mem_do,
    input  req_ready, rsp_valid, rsp_data, rsp_err, mem_we, mem_addr, mem_di
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store front-end for a word-addressed async-read/sync-write DataMemory.
// Sub-word stores are read-modify-write; misaligned/out-of-range requests skip memory.
module mem_access_unit #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_access_unit_if.slave bus
);

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

  state_t                  state, state_nxt;
  logic [2:0]              op_p0;
  logic [31:0]             addr_p0;
  logic [DATA_WIDTH-1:0]   wdata_p0;
  logic [DATA_WIDTH-1:0]   merged_p1;
  logic [DATA_WIDTH-1:0]   rsp_data_p1;
  logic                    rsp_err_p1;
  logic                    accept;
  logic                    is_load_p0;

  function automatic logic access_err(input logic [2:0] op, input logic [31:0] addr);
    logic range_bad;
    logic align_bad;
    range_bad = (addr >> (ADDR_WIDTH + 2)) != 32'd0;
    case (op)
      OP_LW, OP_SW:         align_bad = (addr[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH: align_bad = addr[0];
      default:              align_bad = 1'b0;
    endcase
    return range_bad | align_bad;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] load_extract(input logic [2:0] op,
                                                         input logic [1:0] lane,
                                                         input logic [DATA_WIDTH-1:0] word);
    logic signed [15:0] half;
    logic signed [7:0]  byt;
    half = lane[1] ? word[31:16] : word[15:0];
    byt  = word[{lane, 3'b000} +: 8];
    case (op)
      OP_LH:   return {{16{half[15]}}, half};
      OP_LHU:  return {16'h0000, half};
      OP_LB:   return {{24{byt[7]}}, byt};
      OP_LBU:  return {24'h000000, byt};
      default: return word;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] merge_lane(input logic is_half,
                                                       input logic [1:0] lane,
                                                       input logic [DATA_WIDTH-1:0] word,
                                                       input logic [DATA_WIDTH-1:0] wdata);
    logic [DATA_WIDTH-1:0] m;
    m = word;
    if (is_half) m[{lane[1], 4'b0000} +: 16] = wdata[15:0];
    else         m[{lane, 3'b000} +: 8]      = wdata[7:0];
    return m;
  endfunction

  assign accept     = (state == IDLE) && bus.req_valid;
  assign is_load_p0 = (op_p0 <= OP_LBU);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_di    = 32'h0;
    bus.mem_addr  = {2'b00, addr_p0[31:2]};
    bus.rsp_data  = rsp_data_p1;
    bus.rsp_err   = rsp_err_p1;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid)
          state_nxt = access_err(bus.req_op, bus.req_addr) ? RESP : ACCESS;
      end
      ACCESS: begin
        if (op_p0 == OP_SW) begin
          bus.mem_we = 1'b1;
          bus.mem_di = wdata_p0;
        end
        state_nxt = (op_p0 == OP_SH || op_p0 == OP_SB) ? WRITE : RESP;
      end
      WRITE: begin
        bus.mem_we = 1'b1;
        bus.mem_di = merged_p1;
        state_nxt  = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // p0: request latch; p1: response / merged word captured during ACCESS
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_p0       <= OP_LW;
      addr_p0     <= 32'h0;
      rsp_data_p1 <= '0;
      rsp_err_p1  <= 1'b0;
    end else if (accept) begin
      op_p0       <= bus.req_op;
      addr_p0     <= bus.req_addr;
      rsp_data_p1 <= '0;
      rsp_err_p1  <= access_err(bus.req_op, bus.req_addr);
    end else if (state == ACCESS && is_load_p0) begin
      rsp_data_p1 <= load_extract(op_p0, addr_p0[1:0], bus.mem_do);
    end
  end

  // Store data needs no reset: it only reaches mem_di in states entered after a new accept
  always_ff @(posedge clk) begin
    if (accept) wdata_p0 <= bus.req_wdata;
    if (state == ACCESS) merged_p1 <= merge_lane(op_p0 == OP_SH, addr_p0[1:0], bus.mem_do, wdata_p0);
  end

endmodule
